frame_freeze_ctrl: RTL and testbench

- Consumes f2s_val and decides when the camera framebuffer may be written, so freeze and release happen only on whole-frame boundaries.
- Sits directly downstream of the 2-second frame-stop counter, between the camera write path and the VGA pixel output.
- While a frame is frozen, it overlays a blinking border on the displayed RGB stream and counts frozen frames.

---
 rtl/frame_freeze_ctrl.sv | 177 +++++++++++++++++
 tb/tb_frame_freeze_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_freeze_ctrl.sv
// frame_freeze_ctrl
// Turns the level freeze request from the frame-stop stage into framebuffer
// write permission. Freeze and release only take effect on frame boundaries.
// While frozen it overlays a blinking border on the VGA stream and counts
// frozen frames.
// Optional build macro FREEZE_PROGRESS_BAR_EN adds a non-blinking green
// progress bar near the bottom edge while frozen. The bar's length follows
// frozen_frames.
`timescale 1ns/1ps

module frame_freeze_ctrl #(
    parameter int          H_ACT        = 640,
    parameter int          V_ACT        = 480,
    parameter int          BORDER_W     = 4,
    parameter logic [11:0] BORDER_COLOR = 12'hF00,
    parameter int          BLINK_FRAMES = 15
) (
    input  logic        vga_pclk,
    input  logic        reset,
    input  logic [9:0]  x_pixel,
    input  logic [9:0]  y_pixel,
    input  logic        f2s_val,
    input  logic [11:0] rgb_in,
    output logic [11:0] rgb_out,
    output logic        fb_wr_allow,
    output logic        frozen,
    output logic [7:0]  frozen_frames
);

    localparam logic [9:0] H_ACT_L  = 10'(H_ACT);
    localparam logic [9:0] V_ACT_L  = 10'(V_ACT);
    localparam logic [9:0] BW_L     = 10'(BORDER_W);
    localparam logic [9:0] H_EDGE_L = 10'(H_ACT - BORDER_W);
    localparam logic [9:0] V_EDGE_L = 10'(V_ACT - BORDER_W);
`ifdef FREEZE_PROGRESS_BAR_EN
    localparam logic [9:0] BAR_TOP_L = 10'(V_ACT - 12);
`endif

    // The blink counter only needs to reach BLINK_FRAMES-1.
    localparam int              BC_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_LIVE        = 2'd0,
        ST_ARM_FREEZE  = 2'd1,
        ST_FROZEN      = 2'd2,
        ST_ARM_RELEASE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            yen, yen_q;
    logic            frame_end;
    logic            fb_wr_allow_q, fb_wr_allow_d;
    logic            frozen_q, frozen_d;
    logic [7:0]      frozen_frames_q, frozen_frames_d;
    logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic [11:0]     rgb_q, rgb_d;
    logic            in_active;
    logic            border;

    // frame_end pulses on the last-active-line to first-blank-line transition.
    // yen_q resets to 0, so no pulse can occur on the first cycle after reset.
    assign yen       = (y_pixel < V_ACT_L);
    assign frame_end = yen_q & ~yen;

    // Register the active-line flag so the frame boundary can be detected.
    always_ff @(posedge vga_pclk or posedge reset) begin
        if (reset) yen_q <= 1'b0;
        else       yen_q <= yen;
    end

    // State register.
    always_ff @(posedge vga_pclk or posedge reset) begin
        if (reset) state_q <= ST_LIVE;
        else       state_q <= state_d;
    end

    // Next-state logic. Within each state, a change of request is tested
    // first, so a cancel or release request wins over a coincident frame_end.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LIVE:        if (f2s_val) state_d = ST_ARM_FREEZE;
            ST_ARM_FREEZE:  if (!f2s_val)       state_d = ST_LIVE;
                            else if (frame_end) state_d = ST_FROZEN;
            ST_FROZEN:      if (!f2s_val) state_d = ST_ARM_RELEASE;
            ST_ARM_RELEASE: if (f2s_val)        state_d = ST_FROZEN;
                            else if (frame_end) state_d = ST_LIVE;
            default:        state_d = ST_LIVE;
        endcase
    end

    // Output decode from the upcoming state. Both flags are then registered,
    // so each one changes on the same edge as the state.
    always_comb begin
        fb_wr_allow_d = (state_d == ST_LIVE) || (state_d == ST_ARM_FREEZE);
        frozen_d      = (state_d == ST_FROZEN) || (state_d == ST_ARM_RELEASE);
    end

    // Register the write permission and the frozen flag.
    always_ff @(posedge vga_pclk or posedge reset) begin
        if (reset) begin
            fb_wr_allow_q <= 1'b1;
            frozen_q      <= 1'b0;
        end else begin
            fb_wr_allow_q <= fb_wr_allow_d;
            frozen_q      <= frozen_d;
        end
    end

    // Frozen-frame and blink counters. They are cleared on freeze entry.
    // They advance on every frame_end seen while frozen, and hold their values
    // while live.
    always_comb begin
        frozen_frames_d = frozen_frames_q;
        blink_cnt_d     = blink_cnt_q;
        blink_phase_d   = blink_phase_q;
        if ((state_q == ST_ARM_FREEZE) && (state_d == ST_FROZEN)) begin
            frozen_frames_d = 8'd0;
            blink_cnt_d     = '0;
            blink_phase_d   = 1'b1;
        end else if (((state_q == ST_FROZEN) || (state_q == ST_ARM_RELEASE)) && frame_end) begin
            if (frozen_frames_q != 8'hFF) frozen_frames_d = frozen_frames_q + 8'd1;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Register the counters.
    always_ff @(posedge vga_pclk or posedge reset) begin
        if (reset) begin
            frozen_frames_q <= 8'd0;
            blink_cnt_q     <= '0;
            blink_phase_q   <= 1'b0;
        end else begin
            frozen_frames_q <= frozen_frames_d;
            blink_cnt_q     <= blink_cnt_d;
            blink_phase_q   <= blink_phase_d;
        end
    end

    assign in_active = (x_pixel < H_ACT_L) && (y_pixel < V_ACT_L);
    assign border    = (x_pixel < BW_L) || (x_pixel >= H_EDGE_L) ||
                       (y_pixel < BW_L) || (y_pixel >= V_EDGE_L);

    // Pixel overlay. Blanking is forced to black. Inside the active area the
    // priority is progress bar first, then border, then the camera pixel.
    always_comb begin
        rgb_d = 12'h000;
        if (in_active) begin
            rgb_d = rgb_in;
            if (frozen_q && blink_phase_q && border) rgb_d = BORDER_COLOR;
`ifdef FREEZE_PROGRESS_BAR_EN
            if (frozen_q && (y_pixel >= BAR_TOP_L) && (y_pixel < V_EDGE_L) &&
                ({1'b0, x_pixel[9:1]} < {2'b00, frozen_frames_q}))
                rgb_d = 12'h0F0;
`endif
        end
    end

    // One-cycle pixel pipeline register.
    always_ff @(posedge vga_pclk or posedge reset) begin
        if (reset) rgb_q <= 12'h000;
        else       rgb_q <= rgb_d;
    end

    assign rgb_out       = rgb_q;
    assign fb_wr_allow   = fb_wr_allow_q;
    assign frozen        = frozen_q;
    assign frozen_frames = frozen_frames_q;

endmodule

// File: tb/tb_frame_freeze_ctrl.sv
// Testbench for frame_freeze_ctrl.
// Each frame uses a compressed raster: only a handful of sample pixels per
// frame. The expected pixel for each check is queued when the stimulus is
// driven, then popped and compared once the registered output is available.
`timescale 1ns/1ps

module tb_frame_freeze_ctrl;

    logic        vga_pclk = 1'b0;
    logic        reset;
    logic [9:0]  x_pixel;
    logic [9:0]  y_pixel;
    logic        f2s_val;
    logic [11:0] rgb_in;
    logic [11:0] rgb_out;
    logic        fb_wr_allow;
    logic        frozen;
    logic [7:0]  frozen_frames;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       tag;
        logic [11:0] val;
    } exp_t;

    exp_t exp_q[$];

`ifdef FREEZE_PROGRESS_BAR_EN
    localparam logic BAR_EN = 1'b1;
`else
    localparam logic BAR_EN = 1'b0;
`endif

    frame_freeze_ctrl dut (
        .vga_pclk      (vga_pclk),
        .reset         (reset),
        .x_pixel       (x_pixel),
        .y_pixel       (y_pixel),
        .f2s_val       (f2s_val),
        .rgb_in        (rgb_in),
        .rgb_out       (rgb_out),
        .fb_wr_allow   (fb_wr_allow),
        .frozen        (frozen),
        .frozen_frames (frozen_frames)
    );

    always #5 vga_pclk = ~vga_pclk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one pixel, advance one clock, and optionally check the pixel result.
    task automatic px(input int x, input int y, input logic f, input logic [11:0] rgb,
                      input logic do_chk, input logic [11:0] exp, input string tag);
        exp_t e;
        x_pixel = 10'(x);
        y_pixel = 10'(y);
        f2s_val = f;
        rgb_in  = rgb;
        if (do_chk) begin
            e.tag = tag;
            e.val = exp;
            exp_q.push_back(e);
        end
        @(posedge vga_pclk);
        #1;
        if (do_chk) begin
            e = exp_q.pop_front();
            chk(e.tag, rgb_out, e.val);
        end
    endtask

    // Run one compressed frame. The request level is set separately for the
    // top, middle and bottom segments of the frame.
    task automatic frame(input logic f_top, input logic f_mid, input logic f_end,
                         input logic do_chk, input logic bon);
        px(320, 3,   f_top, 12'h111, do_chk, bon ? 12'hF00 : 12'h111, "row3");
        px(320, 4,   f_top, 12'h222, do_chk, 12'h222,                 "row4");
        px(0,   200, f_mid, 12'h333, do_chk, bon ? 12'hF00 : 12'h333, "col0");
        px(635, 200, f_mid, 12'h444, do_chk, 12'h444,                 "col635");
        px(636, 200, f_mid, 12'h555, do_chk, bon ? 12'hF00 : 12'h555, "col636");
        px(640, 200, f_mid, 12'h666, do_chk, 12'h000,                 "hblank");
        px(320, 479, f_end, 12'h777, do_chk, bon ? 12'hF00 : 12'h777, "row479");
        px(320, 480, f_end, 12'h888, do_chk, 12'h000,                 "vblank");
        px(320, 500, f_end, 12'h999, 1'b0,   12'h000,                 "");
    endtask

    // Expected border visibility in frame k after freeze entry (15-frame blink).
    function automatic logic border_on(input int k);
        return ((k / 15) % 2) == 0;
    endfunction

    initial begin
        reset   = 1'b1;
        x_pixel = 10'd10;
        y_pixel = 10'd300;
        f2s_val = 1'b0;
        rgb_in  = 12'h000;
        repeat (3) @(posedge vga_pclk);
        #1;
        chk("rst_allow",  {11'd0, fb_wr_allow}, 12'd1);
        chk("rst_frozen", {11'd0, frozen},      12'd0);
        chk("rst_rgb",    rgb_out,              12'h000);
        chk("rst_count",  {4'd0, frozen_frames}, 12'd0);
        reset = 1'b0;

        // Live pass-through after a reset in mid-frame.
        px(10,  300, 1'b0, 12'h3C5, 1'b1, 12'h3C5, "live_pass");
        px(700, 300, 1'b0, 12'hFFF, 1'b1, 12'h000, "live_hblank");
        px(10,  479, 1'b0, 12'hABC, 1'b1, 12'hABC, "live_row479");
        px(10,  480, 1'b0, 12'hFFF, 1'b1, 12'h000, "live_vblank");
        px(10,  500, 1'b0, 12'h000, 1'b0, 12'h000, "");
        chk("live_allow",  {11'd0, fb_wr_allow}, 12'd1);
        chk("live_frozen", {11'd0, frozen},      12'd0);

        // Freeze request at y=100 takes effect only after the frame ends.
        px(0, 0,   1'b0, 12'h000, 1'b0, 12'h000, "");
        px(0, 100, 1'b1, 12'h000, 1'b0, 12'h000, "");
        chk("arm_allow",     {11'd0, fb_wr_allow}, 12'd1);
        px(0, 300, 1'b1, 12'h000, 1'b0, 12'h000, "");
        px(0, 479, 1'b1, 12'h000, 1'b0, 12'h000, "");
        chk("arm_allow_479", {11'd0, fb_wr_allow}, 12'd1);
        chk("arm_frozen",    {11'd0, frozen},      12'd0);
        px(0, 480, 1'b1, 12'h000, 1'b0, 12'h000, "");
        chk("frz_allow",     {11'd0, fb_wr_allow}, 12'd0);
        chk("frz_frozen",    {11'd0, frozen},      12'd1);
        chk("frz_count0",    {4'd0, frozen_frames}, 12'd0);
        px(0, 500, 1'b1, 12'h000, 1'b0, 12'h000, "");

        // Forty frozen frames: border on 0-14, off 15-29, on 30-39.
        for (int k = 0; k < 40; k++) begin
            frame(1'b1, 1'b1, 1'b1, 1'b1, border_on(k));
            chk("frz_count", {4'd0, frozen_frames}, 12'(k + 1));
        end

        // Drop, then re-raise before the frame ends: stays frozen, count continues.
        px(320, 3,   1'b1, 12'h000, 1'b0, 12'h000, "");
        px(320, 50,  1'b0, 12'h000, 1'b0, 12'h000, "");
        chk("rel_allow",    {11'd0, fb_wr_allow}, 12'd0);
        chk("rel_frozen",   {11'd0, frozen},      12'd1);
        px(320, 100, 1'b1, 12'h000, 1'b0, 12'h000, "");
        px(320, 479, 1'b1, 12'h000, 1'b0, 12'h000, "");
        px(320, 480, 1'b1, 12'h000, 1'b0, 12'h000, "");
        chk("rearm_allow",  {11'd0, fb_wr_allow}, 12'd0);
        chk("rearm_frozen", {11'd0, frozen},      12'd1);
        chk("rearm_count",  {4'd0, frozen_frames}, 12'd41);
        px(320, 500, 1'b1, 12'h000, 1'b0, 12'h000, "");

        // Drop at y=50 and keep it low: release at the next frame end.
        px(320, 3,   1'b1, 12'h000, 1'b0, 12'h000, "");
        px(320, 50,  1'b0, 12'h000, 1'b0, 12'h000, "");
        px(320, 479, 1'b0, 12'h000, 1'b0, 12'h000, "");
        chk("rel_pre_allow", {11'd0, fb_wr_allow}, 12'd0);
        px(320, 480, 1'b0, 12'h000, 1'b0, 12'h000, "");
        chk("rel_allow1",    {11'd0, fb_wr_allow}, 12'd1);
        chk("rel_frozen0",   {11'd0, frozen},      12'd0);
        chk("rel_count",     {4'd0, frozen_frames}, 12'd42);
        px(320, 500, 1'b0, 12'h000, 1'b0, 12'h000, "");

        // The count is held while live.
        frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hold_count", {4'd0, frozen_frames}, 12'd42);
        chk("hold_allow", {11'd0, fb_wr_allow},  12'd1);

        // A short pulse within one frame never freezes.
        px(320, 3,   1'b0, 12'h000, 1'b0, 12'h000, "");
        px(320, 200, 1'b1, 12'h000, 1'b0, 12'h000, "");
        chk("pulse_allow_hi", {11'd0, fb_wr_allow}, 12'd1);
        px(320, 300, 1'b0, 12'h000, 1'b0, 12'h000, "");
        chk("pulse_allow_lo", {11'd0, fb_wr_allow}, 12'd1);
        px(320, 479, 1'b0, 12'h000, 1'b0, 12'h000, "");
        px(320, 480, 1'b0, 12'h000, 1'b0, 12'h000, "");
        chk("pulse_allow_end", {11'd0, fb_wr_allow}, 12'd1);
        chk("pulse_frozen",    {11'd0, frozen},      12'd0);
        px(320, 500, 1'b0, 12'h000, 1'b0, 12'h000, "");

        // Cancel coinciding with frame_end: the cancel wins.
        px(320, 3,   1'b0, 12'h000, 1'b0, 12'h000, "");
        px(320, 200, 1'b1, 12'h000, 1'b0, 12'h000, "");
        px(320, 479, 1'b1, 12'h000, 1'b0, 12'h000, "");
        px(320, 480, 1'b0, 12'h000, 1'b0, 12'h000, "");
        chk("cancel_allow",  {11'd0, fb_wr_allow}, 12'd1);
        chk("cancel_frozen", {11'd0, frozen},      12'd0);
        px(320, 500, 1'b0, 12'h000, 1'b0, 12'h000, "");
        frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("cancel_allow2", {11'd0, fb_wr_allow}, 12'd1);

        // Long freeze: the new entry clears the count, and the count saturates at 255.
        frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_entry_frozen", {11'd0, frozen},       12'd1);
        chk("sat_entry_count",  {4'd0, frozen_frames}, 12'd0);
        for (int k = 0; k < 100; k++) frame(1'b1, 1'b1, 1'b1, 1'b1, border_on(k));
        chk("count100", {4'd0, frozen_frames}, 12'd100);
        px(199, 470, 1'b1, 12'h789, 1'b1, BAR_EN ? 12'h0F0 : 12'h789, "bar_199");
        px(200, 470, 1'b1, 12'h789, 1'b1, 12'h789,                    "bar_200");
        for (int k = 100; k < 300; k++) frame(1'b1, 1'b1, 1'b1, 1'b1, border_on(k));
        chk("sat_count", {4'd0, frozen_frames}, 12'd255);

        // Reset while frozen returns to live at once.
        px(320, 100, 1'b1, 12'h000, 1'b0, 12'h000, "");
        #2 reset = 1'b1;
        #1;
        chk("rstmid_allow",  {11'd0, fb_wr_allow}, 12'd1);
        chk("rstmid_frozen", {11'd0, frozen},      12'd0);
        chk("rstmid_count",  {4'd0, frozen_frames}, 12'd0);
        @(posedge vga_pclk);
        #1 reset = 1'b0;
        frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_allow", {11'd0, fb_wr_allow}, 12'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
